// File: rtl/spi_master_3wire.sv
// 3-wire SPI initiator for AD9643-style register ports.
// Single-byte read/write commands in; 24-bit MSB-first frames out.
//
// Ports:
//   clk, resetn        system clock, async active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_rw/addr/wdata  1=read; 13-bit address; write byte
//   rsp_valid/rdata    one-cycle completion strobe, read byte
//   busy               high whenever not IDLE
//   sclk, ss_n         SPI clock (CPOL=0), chip select
//   sdio_o/i/t         split SDIO for an external IOBUF
module spi_master_3wire #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        sclk,
  output logic        ss_n,
  output logic        sdio_o,
  input  logic        sdio_i,
  output logic        sdio_t
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW =
    (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    END_S,
    GAP
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_cnt;
  logic          rw_q;
  logic [22:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic          half_done;

  assign half_done = (div_cnt == DIV_LAST);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // bit_cnt is the index of the frame bit currently on the
  // wire; it advances on every falling edge but the last.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      rw_q      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      sclk      <= 1'b0;
      ss_n      <= 1'b1;
      sdio_o    <= 1'b0;
      sdio_t    <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= SHIFT;
            rw_q    <= cmd_rw;
            tx_sr   <= {2'b00, cmd_addr,
                        cmd_rw ? 8'h00 : cmd_wdata};
            rx_sr   <= 8'h00;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            ss_n    <= 1'b0;
            sdio_t  <= 1'b0;
            sdio_o  <= cmd_rw;
          end
        end
        SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              // rising edges 17..24 carry the read byte
              if (rw_q && bit_cnt >= 5'd16)
                rx_sr <= {rx_sr[6:0], sdio_i};
            end else if (bit_cnt == 5'd23) begin
              state <= END_S;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              sdio_o  <= tx_sr[22];
              tx_sr   <= {tx_sr[21:0], 1'b0};
              // release the line after the 16-bit header
              if (rw_q && bit_cnt == 5'd15)
                sdio_t <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        END_S: begin
          if (half_done) begin
            state     <= GAP;
            gap_cnt   <= '0;
            ss_n      <= 1'b1;
            sdio_t    <= 1'b1;
            sdio_o    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rw_q ? rx_sr : 8'h00;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_3wire.sv
// Bench for spi_master_3wire: two instances (default and
// CLK_DIV=1/CS_GAP=1) sharing one SPI register slave model.
module tb_spi_master_3wire;

  localparam int CD_A  = 4;
  localparam int GAP_A = 4;
  localparam int CD_B  = 1;
  localparam int GAP_B = 1;

  typedef struct {
    bit          rw;
    logic [23:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        sdio_s = 1'b0;
  logic        done = 1'b0;
  int          to_err = 0;

  logic       rdy_a, rv_a, busy_a, sclk_a, ss_a;
  logic       so_a, st_a;
  logic [7:0] rd_a;
  logic       rdy_b, rv_b, busy_b, sclk_b, ss_b;
  logic       so_b, st_b;
  logic [7:0] rd_b;

  logic       ready_m, rv_m, busy_m, sclk_m, ss_m;
  logic       so_m, st_m;
  logic [7:0] rd_m;

  always #5 clk = ~clk;

  spi_master_3wire #(
    .CLK_DIV(CD_A),
    .CS_GAP (GAP_A)
  ) dut_a (
    .clk      (clk),
    .resetn   (resetn),
    .cmd_valid(cmd_valid && !sel),
    .cmd_ready(rdy_a),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_a),
    .rsp_rdata(rd_a),
    .busy     (busy_a),
    .sclk     (sclk_a),
    .ss_n     (ss_a),
    .sdio_o   (so_a),
    .sdio_i   (sdio_s),
    .sdio_t   (st_a)
  );

  spi_master_3wire #(
    .CLK_DIV(CD_B),
    .CS_GAP (GAP_B)
  ) dut_b (
    .clk      (clk),
    .resetn   (resetn),
    .cmd_valid(cmd_valid && sel),
    .cmd_ready(rdy_b),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_b),
    .rsp_rdata(rd_b),
    .busy     (busy_b),
    .sclk     (sclk_b),
    .ss_n     (ss_b),
    .sdio_o   (so_b),
    .sdio_i   (sdio_s),
    .sdio_t   (st_b)
  );

  assign ready_m = sel ? rdy_b  : rdy_a;
  assign rv_m    = sel ? rv_b   : rv_a;
  assign rd_m    = sel ? rd_b   : rd_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign sclk_m  = sel ? sclk_b : sclk_a;
  assign ss_m    = sel ? ss_b   : ss_a;
  assign so_m    = sel ? so_b   : so_a;
  assign st_m    = sel ? st_b   : st_a;

  // ---------------- slave register model ----------------
  logic [7:0]  mem   [0:8191];
  bit          mem_v [0:8191];
  logic [23:0] cap = '0;
  logic [23:0] frame_s = '0;
  logic [7:0]  rbyte = '0;
  int          nb_s = 0;
  int          last_nb = 0;
  int          t_bad = 0;
  int          sclk_bad = 0;
  bit          rw_s = 1'b0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  function automatic logic [7:0] preset(
    input logic [12:0] a
  );
    case (a)
      13'h0001: return 8'h82;
      13'h0100: return 8'hA5;
      13'h0000: return 8'h3E;
      default:  return 8'h00;
    endcase
  endfunction

  always @(sclk_m or ss_m) begin
    if (ss_m !== ss_prev) begin
      if (ss_m === 1'b0) begin
        nb_s = 0;
        cap = '0;
        t_bad = 0;
        sdio_s = 1'b0;
      end else begin
        if (sclk_m === 1'b1 && resetn)
          sclk_bad++;
        last_nb = nb_s;
        if (nb_s == 24) begin
          frame_s = cap;
          if (!cap[23]) begin
            mem[cap[20:8]] = cap[7:0];
            mem_v[cap[20:8]] = 1'b1;
          end
        end
        sdio_s = 1'b0;
      end
    end else if (sclk_m === 1'b1 && sclk_prev === 1'b0) begin
      if (ss_m !== 1'b0) begin
        sclk_bad++;
      end else begin
        cap = {cap[22:0], so_m};
        nb_s++;
        if (nb_s == 1)
          rw_s = so_m;
        if (st_m !== (rw_s && nb_s > 16))
          t_bad++;
      end
    end else if (sclk_m === 1'b0 && sclk_prev === 1'b1) begin
      if (ss_m === 1'b0 && rw_s && nb_s >= 16 && nb_s <= 23) begin
        if (nb_s == 16)
          rbyte = mem_v[cap[12:0]] ?
                  mem[cap[12:0]] : preset(cap[12:0]);
        sdio_s = rbyte[23 - nb_s];
      end
    end
    ss_prev = ss_m;
    sclk_prev = sclk_m;
  end

  // ---------------- scoreboard + monitor ----------------
  exp_t exp_q [0:31];
  int   q_wr = 0;
  int   q_rd = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t1 = 0;
  int   gcnt = 0;
  int   cd = CD_A;
  int   gap = GAP_A;
  bit   armed = 1'b0;
  bit   rw_cur = 1'b0;
  bit   t_seen = 1'b0;
  bit   sclk_seen = 1'b0;
  bit   wait_rdy = 1'b0;
  bit   prev_rsp = 1'b0;
  bit   fin = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cd  = sel ? CD_B : CD_A;
    gap = sel ? GAP_B : GAP_A;
    if (!resetn) begin
      chk("reset_state",
          int'({ss_m, sclk_m, so_m, st_m, rv_m,
                busy_m, ready_m, rd_m}),
          int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 8'h00}));
      armed = 1'b0;
      wait_rdy = 1'b0;
      prev_rsp = 1'b0;
    end else begin
      if (armed && cyc == t1)
        chk("t1_pins", int'({ss_m, st_m, so_m, sclk_m}),
            int'({1'b0, 1'b0, rw_cur, 1'b0}));
      if (armed && !ss_m && sclk_m && !sclk_seen) begin
        sclk_seen = 1'b1;
        chk("first_rise", cyc - t1, cd);
      end
      if (armed && rw_cur && !ss_m && st_m && !t_seen) begin
        t_seen = 1'b1;
        chk("sdio_t_rise", cyc - t1, 32 * cd);
      end
      if (prev_rsp)
        chk("rsp_width", int'(rv_m), 0);
      if (rv_m) begin
        if (q_rd == q_wr) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q[q_rd];
          q_rd++;
          chk("rsp_rdata", int'(rd_m), int'(e.rdata));
          chk("rsp_latency", cyc - t1, 49 * cd);
          chk("frame_bits", last_nb, 24);
          chk("frame_hdr",
              int'(e.rw ? (frame_s & 24'hFFFF00) : frame_s),
              int'(e.rw ? (e.frame & 24'hFFFF00) : e.frame));
          chk("sdio_t_pattern", t_bad, 0);
        end
        wait_rdy = 1'b1;
        gcnt = 0;
      end
      if (wait_rdy && ss_m && busy_m)
        gcnt++;
      if (wait_rdy && ready_m) begin
        wait_rdy = 1'b0;
        chk("ready_latency", cyc - t1, 49 * cd + gap);
        chk("ss_gap", gcnt, gap);
      end
      prev_rsp = rv_m;
      if (cmd_valid && ready_m) begin
        t1 = cyc + 1;
        armed = 1'b1;
        rw_cur = cmd_rw;
        t_seen = 1'b0;
        sclk_seen = 1'b0;
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      chk("sclk_outside_cs", sclk_bad, 0);
      chk("timeouts", to_err, 0);
      chk("queue_drained", q_wr - q_rd, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit rw, input logic [12:0] a,
                       input logic [7:0] d, input bit push,
                       input logic [7:0] er);
    int n;
    if (push) begin
      exp_q[q_wr] = '{rw: rw,
                      frame: {rw, 2'b00, a, rw ? 8'h00 : d},
                      rdata: er};
      q_wr++;
    end
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    while (!ready_m && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000)
      to_err++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // fields go to junk so late input changes are exercised
  task automatic drop();
    cmd_valid = 1'b0;
    cmd_rw = 1'b1;
    cmd_addr = 13'h1FFF;
    cmd_wdata = 8'hC3;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_m && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000)
      to_err++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 13'h0016, 8'h5A, 1'b1, 8'h00);
    drop();
    wait_idle();

    issue(1'b1, 13'h0001, 8'h00, 1'b1, 8'h82);
    drop();
    wait_idle();

    issue(1'b0, 13'h1FFF, 8'hFF, 1'b1, 8'h00);
    issue(1'b1, 13'h0000, 8'h00, 1'b1, 8'h3E);
    drop();
    wait_idle();

    issue(1'b0, 13'h0AAA, 8'h11, 1'b0, 8'h00);
    n = 0;
    while (nb_s != 10 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500)
      to_err++;
    resetn = 1'b0;
    drop();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 13'h0005, 8'h3C, 1'b1, 8'h00);
    drop();
    wait_idle();

    issue(1'b0, 13'h000B, 8'h07, 1'b1, 8'h00);
    issue(1'b1, 13'h000B, 8'h00, 1'b1, 8'h07);
    drop();
    wait_idle();

    sel = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b1, 13'h0100, 8'h00, 1'b1, 8'hA5);
    drop();
    wait_idle();

    done = 1'b1;
    repeat (4) @(negedge clk);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_3wire.md
Name: spi_master_3wire

Overview:
- Initiator side of the AD9643-style 3-wire SPI register port. Takes single-byte register read/write commands from a local valid/ready bus and serializes them onto SCLK/CSB/SDIO.
- Returns read data on a response strobe.
- Drives the converter's SPI pins in system designs.
- Also serves as the stimulus engine for the team's SPI slave register model in loopback benches.
- SDIO is split into o/i/t pins for an external IOBUF.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
- CS_GAP, 4, clk cycles ss_n held high after a transfer before the next command is accepted (>=1)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accept; high only in IDLE
- cmd_rw  input  1  1=read, 0=write
- cmd_addr  input  13  register address
- cmd_wdata  input  8  write byte; ignored for reads
- rsp_valid  output  1  one-cycle transfer-complete strobe
- rsp_rdata  output  8  captured read byte; 0x00 after a write
- busy  output  1  high when not IDLE
- sclk  output  1  SPI clock; idles low (CPOL=0)
- ss_n  output  1  chip select, active low
- sdio_o  output  1  serial data to pad
- sdio_i  input  1  serial data from pad
- sdio_t  output  1  IOBUF tristate: 1=input/released, 0=master drives

Behaviour:
- Reset values: ss_n=1, sclk=0, sdio_o=0, sdio_t=1, rsp_valid=0, rsp_rdata=0x00, busy=0, state=IDLE.
- Reset is asynchronous and immediate, including mid-transfer; no rsp_valid is produced for an aborted transfer.
- Frame is 24 bits, MSB first:
  - bit23 = cmd_rw
  - bits22:21 = W1:W0 = 00 (single byte)
  - bits20:8 = cmd_addr
  - bits7:0 = cmd_wdata for writes, or slave data for reads
- Accept: in the cycle T0 where cmd_valid && cmd_ready, all command fields are latched. Later input changes are ignored.
- States: IDLE -> SHIFT -> END -> GAP -> IDLE.
- T1 = T0+1:
  - ss_n=0, sdio_t=0, sdio_o=bit23, sclk=0.
- SHIFT, edge k = 1..24:
  - Rising edge k: sclk goes 1 at T1+(2k-1)*CLK_DIV.
  - Falling edge k: sclk goes 0 at T1+2k*CLK_DIV.
  - sdio_o updates to the next bit in the same cycle as each falling edge 1..23, so data is stable across every rising edge.
- Reads:
  - sdio_t goes 1 at falling edge 16 (T1+32*CLK_DIV) and stays 1 to the end of the transfer.
  - sdio_i is sampled in each cycle where sclk transitions 0->1, for rising edges 17..24, and shifted in MSB first.
- Writes: sdio_t=0 for all 24 bits.
- END:
  - After falling edge 24, sclk stays 0 for CLK_DIV cycles.
  - At T1+49*CLK_DIV: ss_n=1, sdio_t=1, rsp_valid=1 for exactly one cycle, rsp_rdata updated (read byte, or 0x00 for a write).
  - rsp_rdata holds until the next response.
- GAP: ss_n stays 1 for CS_GAP cycles. cmd_ready returns at T1+49*CLK_DIV+CS_GAP.
- Defaults (CLK_DIV=4, CS_GAP=4): rsp_valid at T1+196, cmd_ready at T1+200.
- sclk only toggles while ss_n=0. There is never a partial SCLK pulse at a CS edge.
- A command held valid through GAP is accepted on the first IDLE cycle. Back-to-back transfers therefore have exactly CS_GAP cycles of ss_n high.
- The half-period counter is CLK_DIV wide enough to count to CLK_DIV-1 and wraps to 0 on each sclk toggle.
- The bit counter runs 0..23 and does not wrap within a transfer.

Test Plan:
- Write, addr 0x0016, data 0x5A, defaults -> bits captured on the 24 sclk rising edges = 0x00165A; sdio_t=0 throughout; rsp_valid at T1+196 with rsp_rdata=0x00; cmd_ready at T1+200.
- Read, addr 0x0001, slave model drives 0x82 on falling edges 16..23 -> first 16 bits = 0x8001; sdio_t rises at T1+128; rsp_rdata=0x82.
- Back-to-back: write 0x1FFF/0xFF, then read 0x0000 with cmd_valid held -> ss_n high for exactly 4 cycles between frames; second frame header = 0x8000; both rsp_valid pulses one cycle wide.
- Reset mid-transfer: resetn low at rising edge 10 -> same cycle ss_n=1, sclk=0, sdio_t=1, no rsp_valid. A following write of 0x0005/0x3C after release completes correctly.
- CLK_DIV=1, CS_GAP=1, read 0x0100 with slave data 0xA5 -> sclk toggles every cycle; rsp_valid at T1+49 with rsp_rdata=0xA5; cmd_ready at T1+50.
- Loopback with the team's SPI slave register model: write 0x0B/0x07, then read 0x0B -> rsp_rdata=0x07.
